// File: rtl/mul_pipe.sv
// Pipelined multiply / multiply-accumulate unit with valid/ready on both sides.
// The product is formed and extended at acceptance; later stages only carry it.
module mul_pipe #(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int ACC_W  = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic             sgn,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MAC  = 2'b01,
        OP_LOAD = 2'b10,
        OP_MULX = 2'b11
    } op_e;

    typedef struct packed {
        logic             valid;
        op_e              op;
        logic [ACC_W-1:0] data;
    } stage_t;

    logic             adv;
    logic [2*W-1:0]   prod_u;
    logic [2*W-1:0]   prod_s;
    logic [ACC_W-1:0] ext_prod;
    stage_t           in_stage;
    stage_t           fin;

    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_data_q,  out_data_d;
    logic [ACC_W-1:0] acc_q,       acc_d;

    // A full output register that is not being drained freezes the whole pipe.
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        prod_u   = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        prod_s   = $unsigned($signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b}));
        ext_prod = ACC_W'(prod_u);
        if (sgn) begin
            ext_prod = ACC_W'($signed(prod_s));
        end
        in_stage.valid = in_valid;
        in_stage.op    = op_e'(op);
        in_stage.data  = ext_prod;
    end

    generate
        if (STAGES > 1) begin : g_pipe
            stage_t stg_q [STAGES-1];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: payload is cleared with the valids so a reset leaves no stale operands behind.
                    for (int i = 0; i < STAGES-1; i++) begin
                        stg_q[i] <= '0;
                    end
                end else if (adv) begin
                    // NOTE: state registers use non-blocking assignment so every stage sees pre-edge values.
                    stg_q[0] <= in_stage;
                    for (int i = 1; i < STAGES-1; i++) begin
                        stg_q[i] <= stg_q[i-1];
                    end
                end
            end

            assign fin = stg_q[STAGES-2];
        end else begin : g_direct
            assign fin = in_stage;
        end
    endgenerate

    // The accumulator moves in the same edge as the result it produced, so MACs chain freely.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        acc_d       = acc_q;
        if (adv) begin
            out_valid_d = fin.valid;
            if (fin.valid) begin
                case (fin.op)
                    OP_MAC: begin
                        out_data_d = acc_q + fin.data;
                        acc_d      = acc_q + fin.data;
                    end
                    OP_LOAD: begin
                        out_data_d = fin.data;
                        acc_d      = fin.data;
                    end
                    default: begin
                        out_data_d = fin.data;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: doc/mul_pipe.md
Name: mul_pipe

Overview:
- Parametrised pipelined multiply / multiply-accumulate unit. Successor to the single-register 8x8 multiplier.
- Adds configurable operand width and pipeline depth, per-operation signed/unsigned selection, and an internal accumulator (MUL / MAC / LOAD modes).
- Uses valid/ready handshakes on both sides, so it can sit between streaming producers and consumers in the datapath.

Parameters:
- W, 8: operand width in bits (>=2).
- STAGES, 2: register stages from input acceptance to output register, inclusive (>=1).
- ACC_W, 24: accumulator and result width (>=2*W).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  unit accepts the operation this cycle.
- a  input  W  operand A.
- b  input  W  operand B.
- sgn  input  1  1 = two's-complement operands, 0 = unsigned.
- op  input  2  00 MUL, 01 MAC, 10 LOAD, 11 treated as MUL.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_data  output  ACC_W  result.

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n). While rst_n=0, all stage valids, out_valid, out_data and the accumulator are 0, and in_ready reads 1 once the output stage is empty. Reset mid-operation discards all in-flight operations and the accumulator value, with no output.
- Advance rule:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - When adv=0, every stage holds, including bubbles.
  - Handshake on the input side: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
- Pipeline and latency:
  - Each stage carries valid, product-or-operands, sgn and op.
  - Product is computed at full 2W width: signed when sgn=1, unsigned otherwise.
  - Product is then sign- or zero-extended to ACC_W.
  - An operation accepted at edge N appears with out_valid=1 after edge N+STAGES-1 if adv stays 1. STAGES=1 means the result is registered on the accepting edge.
  - The split of the multiply across stages is implementation choice; result and latency are not.
  - Order is strictly preserved. Throughput is 1 op/cycle when out_ready=1.
- Output stage, updated on an edge where adv=1 and the final internal stage is valid:
  - MUL (and 11): out_data = ext(product); accumulator unchanged.
  - MAC: out_data = acc + ext(product), modulo 2^ACC_W; acc takes the same value.
  - LOAD: out_data = ext(product); acc = ext(product).
  - If the final stage is a bubble and adv=1, out_valid goes to 0 and out_data holds its last value.
- Accumulator update is coincident with the result entering the output register. Back-to-back MACs therefore chain with no hazard.
- Arithmetic wraps silently; there is no saturation or overflow flag.
- Simultaneous events: when out_valid && out_ready && a new result arrives on the same edge, the output is replaced (no loss, no duplicate). When held (out_ready=0), out_data and out_valid are stable and no new input is accepted.

Test Plan (W=8, STAGES=2, ACC_W=24 unless noted):
1. Unsigned MUL: a=2,b=2 then a=2,b=3 on consecutive cycles, out_ready=1 -> out_data 0x000004 then 0x000006, each one cycle after acceptance (cycle after), out_valid contiguous.
2. Signedness: a=0xFE, b=3, sgn=1, MUL -> 0xFFFFFA; same operands with sgn=0 -> 0x0002FA.
3. Accumulate chain: LOAD 10*10 -> 100; MAC 5*4 -> 120; MAC 255*255 (sgn=0) -> 65145 (0x00FE79); following MUL 1*1 -> 1 with acc still 65145; next MAC 0*0 -> 65145.
4. Accumulator wrap: LOAD a=0xFF,b=1,sgn=1 -> 0xFFFFFF; MAC 1*1 -> 0x000000.
5. Backpressure: stream 4 MULs (1*1, 2*2, 3*3, 4*4) with out_ready low for 3 cycles after the first result:
   - in_ready=0 throughout the stall.
   - out_data held at 1.
   - After release, outputs are exactly 1, 4, 9, 16 in order.
   - No in_valid accepted while in_ready=0.
6. Reset mid-flight: accept LOAD 7*7 and MAC 2*2, assert rst_n=0 asynchronously between edges -> out_valid and out_data are 0 immediately. After release, MAC 3*3 -> 9, proving acc was cleared. STAGES=1 rerun of scenario 1 -> results on the accepting edge.
